// File: rtl/player.sv
// Sample playback engine: the host fills the buffer on h_clk, and releasing w_reset_n streams w_len samples out on w_clk.
// Optional build macro PLAYER_LOOP_EN repeats the buffer without a gap instead of stopping.
module player #(
  parameter int width    = 8,
  parameter int timeBits = 10
) (
  input  logic                w_clk,
  input  logic                w_reset_n,
  input  logic [timeBits:0]   w_len,
  output logic [width-1:0]    w_out,
  output logic                w_valid,
  output logic                w_done,
  input  logic                h_clk,
  input  logic                h_write,
  input  logic [timeBits-1:0] h_addr,
  input  logic [width-1:0]    h_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [width-1:0] mem [2**timeBits];

  state_t              state_q, state_d;
  logic [timeBits-1:0] addr_q, addr_d;
  logic [timeBits:0]   count_q, count_d;
  logic [timeBits:0]   len_q;
  logic [width-1:0]    out_q;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                rd_en;
  logic [timeBits-1:0] rd_addr;

  always_ff @(posedge h_clk) begin
    if (h_write) begin
      mem[h_addr] <= h_data;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (len_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          rd_en   = 1'b1;
          rd_addr = '0;
          addr_d  = {{(timeBits-1){1'b0}}, 1'b1};
          count_d = {{timeBits{1'b0}}, 1'b1};
          valid_d = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (count_q < len_q) begin
          rd_en   = 1'b1;
          rd_addr = addr_q;
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          valid_d = 1'b1;
        end else begin
`ifdef PLAYER_LOOP_EN
          rd_en   = 1'b1;
          rd_addr = '0;
          addr_d  = {{(timeBits-1){1'b0}}, 1'b1};
          count_d = {{timeBits{1'b0}}, 1'b1};
          valid_d = 1'b1;
`else
          // w_out keeps the last sample: no read is issued on this edge.
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= w_len;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (rd_en) begin
        out_q <= mem[rd_addr];
      end
    end
  end

  assign w_out   = out_q;
  assign w_valid = valid_q;
  assign w_done  = done_q;

endmodule

// File: tb/tb_player.sv
// Directed self-checking bench for player; one-shot tests by default, loop test when PLAYER_LOOP_EN is defined.
module tb_player;

  localparam int WIDTH = 8;
  localparam int TB    = 10;

  logic              w_clk = 1'b0;
  logic              h_clk = 1'b0;
  logic              w_reset_n = 1'b0;
  logic [TB:0]       w_len = '0;
  logic [WIDTH-1:0]  w_out;
  logic              w_valid;
  logic              w_done;
  logic              h_write = 1'b0;
  logic [TB-1:0]     h_addr = '0;
  logic [WIDTH-1:0]  h_data = '0;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 w_clk = ~w_clk;
  always #7 h_clk = ~h_clk;

  player #(.width(WIDTH), .timeBits(TB)) dut (
    .w_clk    (w_clk),
    .w_reset_n(w_reset_n),
    .w_len    (w_len),
    .w_out    (w_out),
    .w_valid  (w_valid),
    .w_done   (w_done),
    .h_clk    (h_clk),
    .h_write  (h_write),
    .h_addr   (h_addr),
    .h_data   (h_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hwrite(input logic [TB-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge h_clk);
    h_write = 1'b1;
    h_addr  = a;
    h_data  = d;
    @(posedge h_clk);
    #1;
    h_write = 1'b0;
  endtask

  // Hold reset two edges with the given length, check cleared outputs, then release.
  task automatic start(input logic [TB:0] len, input string tag);
    @(negedge w_clk);
    w_reset_n = 1'b0;
    w_len     = len;
    @(posedge w_clk);
    @(posedge w_clk);
    #1;
    check({tag, " rst out"},   w_out,   32'h0);
    check({tag, " rst valid"}, w_valid, 32'h0);
    check({tag, " rst done"},  w_done,  32'h0);
    @(negedge w_clk);
    w_reset_n = 1'b1;
  endtask

  task automatic expect_sample(input string tag, input logic [WIDTH-1:0] v);
    @(posedge w_clk);
    #1;
    check({tag, " out"},   w_out,   v);
    check({tag, " valid"}, w_valid, 32'h1);
    check({tag, " done"},  w_done,  32'h0);
  endtask

  task automatic expect_done(input string tag, input logic [WIDTH-1:0] v);
    @(posedge w_clk);
    #1;
    check({tag, " out"},   w_out,   v);
    check({tag, " valid"}, w_valid, 32'h0);
    check({tag, " done"},  w_done,  32'h1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) hwrite(i[TB-1:0], 8'h10 + i[7:0]);

    // Zero length: straight to done
    start(11'd0, "t2");
    for (int i = 0; i < 3; i++) expect_done("t2", 8'h00);

    // Reset mid-play, then replay from the start
    start(11'd8, "t4");
    for (int k = 0; k < 3; k++) expect_sample("t4", 8'h10 + k[7:0]);
    @(negedge w_clk);
    w_reset_n = 1'b0;
    @(posedge w_clk);
    #1;
    check("t4 midrst out",   w_out,   32'h0);
    check("t4 midrst valid", w_valid, 32'h0);
    check("t4 midrst done",  w_done,  32'h0);
    @(negedge w_clk);
    w_reset_n = 1'b1;
    expect_sample("t4 replay", 8'h10);
    expect_sample("t4 replay", 8'h11);

`ifndef PLAYER_LOOP_EN
    // One-shot of 4 samples
    start(11'd4, "t1");
    for (int k = 0; k < 4; k++) expect_sample("t1", 8'h10 + k[7:0]);
    for (int i = 0; i < 3; i++) expect_done("t1 hold", 8'h13);

    // w_len changes while playing are ignored
    start(11'd4, "t5");
    expect_sample("t5", 8'h10);
    @(negedge w_clk);
    w_len = 11'd8;
    for (int k = 1; k < 4; k++) expect_sample("t5", 8'h10 + k[7:0]);
    expect_done("t5 end", 8'h13);
    expect_done("t5 hold", 8'h13);

    // Full buffer
    for (int i = 0; i < 1024; i++) hwrite(i[TB-1:0], i[7:0]);
    start(11'd1024, "t3");
    for (int k = 0; k < 1024; k++) expect_sample("t3", k[7:0]);
    expect_done("t3 end", 8'hFF);
    expect_done("t3 hold", 8'hFF);
`else
    // Looping playback of 3 samples
    start(11'd3, "t6");
    for (int k = 0; k < 24; k++) expect_sample("t6", 8'h10 + 8'(k % 3));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
